alu_issue_unit: RTL and testbench

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_unit.sv | 200 ++++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Purpose:
//   Small issue/sequencing unit that sits in front of an external 8-bit ALU.
//   It holds a 4x8 register file (R0..R3). It accepts one instruction at a
//   time and snapshots both operands at accept. It drives the ALU for one
//   EXEC cycle, or for several cycles when repeated shifts are enabled. It
//   captures the ALU result and flags, then writes them back in a WB cycle
//   that raises a one-cycle done pulse.
//
// Optional feature:
//   ALU_ISSUE_REPEAT_EN - when defined, shift ops (10/11) run
//   max(instr_count,1) EXEC passes. Each pass feeds its result back as the
//   next alu_a. When undefined, instr_count is ignored and every op is a
//   single pass.
//
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   instr_valid/instr_ready  - instruction handshake (ready only in IDLE)
//   instr_op/rd/rs/count     - opcode, dest/first operand, second operand,
//                              shift repeat count
//   load_valid/addr/data     - direct register-file write port
//   alu_select/alu_a/alu_b   - drive to external ALU (zero outside EXEC)
//   alu_result + 4 flags     - returned from external ALU
//   flags                    - registered {C,V,Z,N}
//   done                     - one-cycle pulse in the WB cycle
//   rd_addr/rd_data          - combinational register-file read port
// ---------------------------------------------------------------------------
module alu_issue_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] instr_op,
  input  logic [1:0] instr_rd,
  input  logic [1:0] instr_rs,
  input  logic [2:0] instr_count,
  input  logic       load_valid,
  input  logic [1:0] load_addr,
  input  logic [7:0] load_data,
  output logic [1:0] alu_select,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_negative,
  output logic [3:0] flags,
  output logic       done,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] regs [4];
  logic [1:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] result_q;
  logic [3:0] flags_cap;
  logic [3:0] flags_q;
  logic       accept;

`ifdef ALU_ISSUE_REPEAT_EN
  logic [2:0] count_q;
  logic       repeat_more;

  // Another pass is needed while more than one pass remains.
  assign repeat_more = (count_q > 3'd1);
`else
  // The repeat count has no function in the single-pass build.
  logic       unused_count;
  assign unused_count = ^instr_count;
`endif

  assign accept  = instr_valid && (state == IDLE);
  assign flags   = flags_q;
  assign rd_data = regs[rd_addr];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> EXEC on accept. EXEC -> WB after the last
  // pass. WB always returns to IDLE, so throughput is one instruction per
  // 3 cycles.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (instr_valid) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
`ifdef ALU_ISSUE_REPEAT_EN
        if (repeat_more) begin
          state_next = EXEC;
        end else begin
          state_next = WB;
        end
`else
        state_next = WB;
`endif
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The ALU bus is quiet outside EXEC. done is masked by
  // reset so that aborting during WB produces no visible pulse.
  always_comb begin
    instr_ready = (state == IDLE);
    alu_select  = 2'b00;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    done        = (state == WB) && !reset;
    if (state == EXEC) begin
      alu_select = op_q;
      alu_a      = a_q;
      alu_b      = b_q;
    end
  end

  // Datapath. Operands are snapshotted at accept, so later loads cannot
  // disturb an in-flight instruction. The WB write is placed after the load
  // write so that it wins on a same-index collision. Reset has priority over
  // everything, including a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
      op_q      <= 2'b00;
      rd_q      <= 2'b00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      result_q  <= 8'h00;
      flags_cap <= 4'h0;
      flags_q   <= 4'h0;
`ifdef ALU_ISSUE_REPEAT_EN
      count_q   <= 3'd0;
`endif
    end else begin
      if (accept) begin
        op_q <= instr_op;
        rd_q <= instr_rd;
        a_q  <= regs[instr_rd];
        b_q  <= regs[instr_rs];
`ifdef ALU_ISSUE_REPEAT_EN
        // Shifts run max(count,1) passes; add/sub always run one.
        if (instr_op[1] && (instr_count != 3'd0)) begin
          count_q <= instr_count;
        end else begin
          count_q <= 3'd1;
        end
`endif
      end

      if (state == EXEC) begin
        // Capture every pass; the final pass leaves the values used at WB.
        result_q  <= alu_result;
        flags_cap <= {alu_carry, alu_overflow, alu_zero, alu_negative};
`ifdef ALU_ISSUE_REPEAT_EN
        a_q <= alu_result;
        if (repeat_more) begin
          count_q <= count_q - 3'd1;
        end
`endif
      end

      if (load_valid) begin
        regs[load_addr] <= load_data;
      end

      if (state == WB) begin
        regs[rd_q] <= result_q;
        flags_q    <= flags_cap;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_unit
//
// Directed bench for alu_issue_unit. A behavioural ALU answers the unit's
// alu_select/alu_a/alu_b combinationally. Its carry on subtract means
// "borrow". Expected results are hand-computed constants. Build with or
// without ALU_ISSUE_REPEAT_EN; the repeat scenario picks its expectations
// to match the build.
// ---------------------------------------------------------------------------
module tb_alu_issue_unit;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs;
  logic [2:0] instr_count;
  logic       load_valid;
  logic [1:0] load_addr;
  logic [7:0] load_data;
  logic [1:0] alu_select;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_overflow;
  logic       alu_zero;
  logic       alu_negative;
  logic [3:0] flags;
  logic       done;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  int checks;
  int fails;

  alu_issue_unit dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs     (instr_rs),
    .instr_count  (instr_count),
    .load_valid   (load_valid),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .alu_select   (alu_select),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .flags        (flags),
    .done         (done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 00 add, 01 sub (carry = borrow), 10 shl1, 11 shr1.
  always_comb begin
    logic [8:0] wide;
    wide         = 9'h000;
    alu_result   = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_select)
      2'b00: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[7:0];
        alu_carry    = wide[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      2'b01: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      2'b10: begin
        alu_result   = {alu_a[6:0], 1'b0};
        alu_carry    = alu_a[7];
        alu_overflow = alu_a[7] ^ alu_result[7];
      end
      default: begin
        alu_result = {1'b0, alu_a[7:1]};
        alu_carry  = alu_a[0];
      end
    endcase
    alu_zero     = (alu_result == 8'h00);
    alu_negative = alu_result[7];
  end

  // Direct register write lasting one clock.
  task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Issue one instruction and follow it to writeback. lat is the cycle
  // (counted from the accept edge) in which done was seen, or -1 on
  // timeout. ready_low counts cycles with instr_ready low. exec_snap
  // records the ALU bus in the first EXEC cycle.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [2:0] cnt,
                       output int lat, output int ready_low,
                       output logic [17:0] exec_snap);
    int guard;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_count = cnt;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    exec_snap   = {alu_select, alu_a, alu_b};
    lat         = 1;
    ready_low   = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (instr_ready !== 1'b1) ready_low++;
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      lat = -1;
    end else if (instr_ready !== 1'b1) begin
      ready_low++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (instr_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_ready: got %b expected 1", instr_ready);
    end
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (flags !== 4'h0) begin
      fails++; $display("[TB] FAIL reset_flags: got %h expected 0", flags);
    end
    checks++;
    if ({alu_select, alu_a, alu_b} !== 18'h0) begin
      fails++; $display("[TB] FAIL reset_alu_bus: got %h expected 0", {alu_select, alu_a, alu_b});
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[1:0];
      #1;
      checks++;
      if (rd_data !== 8'h00) begin
        fails++; $display("[TB] FAIL reset_reg%0d: got %h expected 00", i, rd_data);
      end
    end
  endtask

  task automatic test_add;
    int lat, rlow;
    logic [17:0] snap;
    do_load(2'd0, 8'h7F);
    do_load(2'd1, 8'h01);
    issue(2'b00, 2'd0, 2'd1, 3'd5, lat, rlow, snap);
    checks++;
    if (lat != 2) begin
      fails++; $display("[TB] FAIL add_latency: got %0d expected 2", lat);
    end
    checks++;
    if (snap !== {2'b00, 8'h7F, 8'h01}) begin
      fails++; $display("[TB] FAIL add_exec_bus: got %h expected %h", snap, {2'b00, 8'h7F, 8'h01});
    end
    rd_addr = 2'd0;
    #1;
    checks++;
    if (rd_data !== 8'h80) begin
      fails++; $display("[TB] FAIL add_r0: got %h expected 80", rd_data);
    end
    checks++;
    if (flags !== 4'b0101) begin
      fails++; $display("[TB] FAIL add_flags: got %b expected 0101", flags);
    end
    checks++;
    if (done !== 1'b0 || {alu_select, alu_a, alu_b} !== 18'h0) begin
      fails++; $display("[TB] FAIL add_after_wb: got done=%b bus=%h expected 0/0", done, {alu_select, alu_a, alu_b});
    end
  endtask

  task automatic test_sub_zero;
    int lat, rlow;
    logic [17:0] snap;
    do_load(2'd2, 8'h05);
    do_load(2'd3, 8'h05);
    issue(2'b01, 2'd2, 2'd3, 3'd0, lat, rlow, snap);
    checks++;
    if (lat != 2) begin
      fails++; $display("[TB] FAIL sub_latency: got %0d expected 2", lat);
    end
    checks++;
    if (rlow != 2) begin
      fails++; $display("[TB] FAIL sub_ready_low: got %0d expected 2", rlow);
    end
    rd_addr = 2'd2;
    #1;
    checks++;
    if (rd_data !== 8'h00) begin
      fails++; $display("[TB] FAIL sub_r2: got %h expected 00", rd_data);
    end
    checks++;
    if (flags !== 4'b0010) begin
      fails++; $display("[TB] FAIL sub_flags: got %b expected 0010", flags);
    end
  endtask

  task automatic test_same_reg_and_shr;
    int lat, rlow;
    logic [17:0] snap;
    do_load(2'd3, 8'h40);
    issue(2'b00, 2'd3, 2'd3, 3'd0, lat, rlow, snap);
    rd_addr = 2'd3;
    #1;
    checks++;
    if (rd_data !== 8'h80 || flags !== 4'b0101) begin
      fails++; $display("[TB] FAIL same_reg_add: got %h/%b expected 80/0101", rd_data, flags);
    end
    // Count 0 on a shift still means one pass.
    do_load(2'd2, 8'h01);
    issue(2'b11, 2'd2, 2'd0, 3'd0, lat, rlow, snap);
    rd_addr = 2'd2;
    #1;
    checks++;
    if (lat != 2 || rd_data !== 8'h00 || flags !== 4'b1010) begin
      fails++; $display("[TB] FAIL shr_one: got lat=%0d %h/%b expected 2 00/1010", lat, rd_data, flags);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ops [3];
    logic [1:0] rds [3];
    logic [1:0] rss [3];
    int acc_cyc [3];
    int accepts, dones, idx;
    logic will_accept;
    ops = '{2'b00, 2'b00, 2'b01};
    rds = '{2'd0, 2'd2, 2'd3};
    rss = '{2'd1, 2'd0, 2'd2};
    do_load(2'd0, 8'h01);
    do_load(2'd1, 8'h02);
    do_load(2'd2, 8'h03);
    do_load(2'd3, 8'h04);
    accepts = 0; dones = 0; idx = 0;
    acc_cyc = '{0, 0, 0};
    instr_valid = 1'b1;
    instr_op = ops[0]; instr_rd = rds[0]; instr_rs = rss[0]; instr_count = 3'd0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      will_accept = instr_valid && instr_ready;
      if (will_accept && accepts < 3) begin
        acc_cyc[accepts] = cyc;
      end
      if (will_accept) accepts++;
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
      if (will_accept) begin
        idx++;
        if (idx < 3) begin
          instr_op = ops[idx]; instr_rd = rds[idx]; instr_rs = rss[idx];
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (accepts != 3 || dones != 3) begin
      fails++; $display("[TB] FAIL b2b_counts: got acc=%0d done=%0d expected 3/3", accepts, dones);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      fails++; $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d expected step 3", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
    rd_addr = 2'd0; #1;
    checks++;
    if (rd_data !== 8'h03) begin
      fails++; $display("[TB] FAIL b2b_r0: got %h expected 03", rd_data);
    end
    rd_addr = 2'd2; #1;
    checks++;
    if (rd_data !== 8'h06) begin
      fails++; $display("[TB] FAIL b2b_r2: got %h expected 06", rd_data);
    end
    rd_addr = 2'd3; #1;
    checks++;
    if (rd_data !== 8'hFE) begin
      fails++; $display("[TB] FAIL b2b_r3: got %h expected FE", rd_data);
    end
  endtask

  task automatic test_load_collision;
    int guard;
    do_load(2'd0, 8'h08);
    do_load(2'd1, 8'h08);
    instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd0; instr_rs = 2'd1; instr_count = 3'd0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    // EXEC: overwrite an operand register; the in-flight add must not see it.
    do_load(2'd1, 8'h77);
    guard = 0;
    while (done !== 1'b1 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (done !== 1'b1) begin
      fails++; $display("[TB] FAIL collide_done: got %b expected 1", done);
    end
    do_load(2'd0, 8'hAA);
    rd_addr = 2'd0; #1;
    checks++;
    if (rd_data !== 8'h10) begin
      fails++; $display("[TB] FAIL collide_r0: got %h expected 10", rd_data);
    end
    rd_addr = 2'd1; #1;
    checks++;
    if (rd_data !== 8'h77) begin
      fails++; $display("[TB] FAIL collide_r1: got %h expected 77", rd_data);
    end
  endtask

  task automatic test_reset_abort;
    int done_seen;
    // Abort in EXEC, with a same-cycle load that reset must override.
    do_load(2'd0, 8'h7F);
    do_load(2'd1, 8'h01);
    instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd0; instr_rs = 2'd1; instr_count = 3'd0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    load_valid = 1'b1; load_addr = 2'd2; load_data = 8'h55;
    @(posedge clk); #1;
    reset = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b1 || flags !== 4'h0) begin
      fails++; $display("[TB] FAIL abort_exec_state: got ready=%b flags=%b expected 1/0000", instr_ready, flags);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[1:0];
      #1;
      checks++;
      if (rd_data !== 8'h00) begin
        fails++; $display("[TB] FAIL abort_exec_reg%0d: got %h expected 00", i, rd_data);
      end
    end
    done_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      fails++; $display("[TB] FAIL abort_exec_done: got %0d pulses expected 0", done_seen);
    end
    // Abort in WB.
    do_load(2'd0, 8'h7F);
    do_load(2'd1, 8'h01);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("[TB] FAIL abort_wb_done: got %b expected 0", done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rd_addr = 2'd0; #1;
    checks++;
    if (rd_data !== 8'h00 || flags !== 4'h0 || instr_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL abort_wb_state: got r0=%h flags=%b ready=%b expected 00/0000/1", rd_data, flags, instr_ready);
    end
  endtask

  task automatic test_repeat_shift;
    int lat, rlow;
    logic [17:0] snap;
    int exp_lat;
    logic [7:0] exp_r1;
    logic [3:0] exp_flags;
`ifdef ALU_ISSUE_REPEAT_EN
    exp_lat = 4; exp_r1 = 8'h08; exp_flags = 4'b0000;
`else
    exp_lat = 2; exp_r1 = 8'h02; exp_flags = 4'b1100;
`endif
    do_load(2'd1, 8'h81);
    issue(2'b10, 2'd1, 2'd0, 3'd3, lat, rlow, snap);
    checks++;
    if (lat != exp_lat) begin
      fails++; $display("[TB] FAIL shl_latency: got %0d expected %0d", lat, exp_lat);
    end
    rd_addr = 2'd1; #1;
    checks++;
    if (rd_data !== exp_r1) begin
      fails++; $display("[TB] FAIL shl_r1: got %h expected %h", rd_data, exp_r1);
    end
    checks++;
    if (flags !== exp_flags) begin
      fails++; $display("[TB] FAIL shl_flags: got %b expected %b", flags, exp_flags);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_op = 2'b00;
    instr_rd = 2'd0;
    instr_rs = 2'd0;
    instr_count = 3'd0;
    load_valid = 1'b0;
    load_addr = 2'd0;
    load_data = 8'h00;
    rd_addr = 2'd0;
    @(posedge clk); #1;
    test_reset;
    test_add;
    test_sub_zero;
    test_same_reg_and_shr;
    test_back_to_back;
    test_load_collision;
    test_reset_abort;
    test_repeat_shift;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
